// File: rtl/brom_reader.sv
// Purpose: walks len consecutive ROM addresses from base (mod 2^ADDR_W) and streams the words out.
// Latency: start sampled -> rom_addr=base next cycle -> first out_valid three cycles after start.
// Backpressure: out_ready stalls issue through a 2-entry skid FIFO; no word is dropped or repeated.
//
// Ports: clock/reset (async active-low); start/base/len command (taken only when idle);
// busy/done status; rom_addr/rom_data to the registered-read ROM; out_valid/out_ready/
// out_data/out_last output stream.

// Small generic FIFO (DEPTH must be a power of two). Head word is visible
// combinationally; storage resets to zero so the head reads 0 after reset.
module brom_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && (count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The producer gates its pushes on occupancy, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(push && full));
endmodule

module brom_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             in_flight;
  logic             in_flight_last;
  word_t            push_word;
  word_t            head;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic             pop;
  logic             issue;
  logic             issue_last;

  assign pop        = out_valid && out_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, in_flight};
  // Issue only if the word it produces is guaranteed a FIFO slot two edges later,
  // counting a slot freed by a pop happening this cycle.
  assign issue      = (state == ISSUE) && ((occupancy - {2'b00, pop}) < 3'd2);
  assign issue_last = (remaining == CNT_W'(1));

  assign push_word  = {in_flight_last, rom_data};
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head.data;
  assign out_last   = out_valid && head.last;

  brom_fifo #(.WIDTH($bits(word_t)), .DEPTH(2)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_flight),
    .push_dat (push_word),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      rom_addr       <= '0;
      remaining      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      done           <= 1'b0;
      // The ROM read issued this cycle lands on rom_data next cycle and is pushed at the following edge.
      in_flight      <= issue;
      in_flight_last <= issue && issue_last;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              rom_addr  <= base;
              remaining <= len;
              state     <= ISSUE;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // rom_addr is the address being presented; it advances only when consumed,
          // and stays on the final address once the last one is issued.
          if (issue) begin
            remaining <= remaining - CNT_W'(1);
            if (issue_last) state <= DRAIN;
            else            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_brom_reader.sv
// Purpose: directed self-checking bench for brom_reader with a registered-read ROM model.
// Latency: checks the three-cycle start-to-first-word timing and one-cycle done pulse.
// Backpressure: drives a repeating out_ready pattern and checks order and hold stability.
module tb_brom_reader;
  logic        clock;
  logic        reset;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  logic [15:0] rom_img [1024];
  logic [15:0] exp8 [8];
  logic [9:0]  wrap_addr [4];
  logic [15:0] wrap_dat [4];
  logic [7:0]  bp_pat;
  logic        held;
  logic [15:0] held_dat;
  logic        got_done;
  int          n_words;
  int          checks;
  int          passes;

  brom_reader #(.ADDR_W(10), .DATA_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One-cycle registered-read ROM.
  always @(posedge clock) rom_data <= rom_img[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Presents a command for one cycle; returns at the negedge of the cycle after it is sampled.
  task automatic launch(input logic [9:0] b, input logic [10:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    for (int i = 0; i < 1024; i++) rom_img[i] = 16'h0000;
    rom_img[0] = 16'hC1A1; rom_img[1] = 16'hA2B2; rom_img[2] = 16'hDAC3; rom_img[3] = 16'hFCD4;
    rom_img[4] = 16'h12E5; rom_img[5] = 16'h03F6; rom_img[6] = 16'h2117; rom_img[7] = 16'h4428;
    exp8[0] = 16'hC1A1; exp8[1] = 16'hA2B2; exp8[2] = 16'hDAC3; exp8[3] = 16'hFCD4;
    exp8[4] = 16'h12E5; exp8[5] = 16'h03F6; exp8[6] = 16'h2117; exp8[7] = 16'h4428;
    wrap_addr[0] = 10'd1022; wrap_addr[1] = 10'd1023; wrap_addr[2] = 10'd0; wrap_addr[3] = 10'd1;
    wrap_dat[0] = 16'h0000; wrap_dat[1] = 16'h0000; wrap_dat[2] = 16'hC1A1; wrap_dat[3] = 16'hA2B2;
    bp_pat = 8'b0110_1001;   // bit k is out_ready in cycle k: 1,0,0,1,0,1,1,0

    // Power-on reset
    reset = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) step();
    reset = 1'b1;
    step();

    // Burst base=0 len=8, consumer always ready
    launch(10'd0, 11'd8);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_addr_c1", 32'(rom_addr), 32'd0);
    chk("t1_vld_c1", 32'(out_valid), 32'd0);
    step();
    chk("t1_vld_c2", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_vld", 32'(out_valid), 32'd1);
      chk("t1_dat", 32'(out_data), 32'(exp8[i]));
      chk("t1_last", 32'(out_last), 32'(i == 7));
      chk("t1_no_early_done", 32'(done), 32'd0);
    end
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_vld_off", 32'(out_valid), 32'd0);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Same burst under a repeating out_ready pattern
    launch(10'd0, 11'd8);
    n_words  = 0;
    got_done = 1'b0;
    held     = 1'b0;
    held_dat = '0;
    for (int k = 0; k < 80 && !got_done; k++) begin
      if (k > 0) step();
      if (done) got_done = 1'b1;
      out_ready = bp_pat[k % 8];
      if (held) begin
        chk("t2_hold_vld", 32'(out_valid), 32'd1);
        chk("t2_hold_dat", 32'(out_data), 32'(held_dat));
      end
      if (out_valid && out_ready) begin
        if (n_words < 8) begin
          chk("t2_dat", 32'(out_data), 32'(exp8[n_words]));
          chk("t2_last", 32'(out_last), 32'(n_words == 7));
        end
        n_words++;
      end
      held     = out_valid && !out_ready;
      held_dat = out_data;
    end
    chk("t2_done_seen", 32'(got_done), 32'd1);
    chk("t2_word_count", 32'(n_words), 32'd8);
    out_ready = 1'b1;
    step();

    // Address wrap: base=1022 len=4
    launch(10'd1022, 11'd4);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step();
      if (c <= 4) chk("t3_addr", 32'(rom_addr), 32'(wrap_addr[c-1]));
      if (c >= 3 && c <= 6) begin
        chk("t3_vld", 32'(out_valid), 32'd1);
        chk("t3_dat", 32'(out_data), 32'(wrap_dat[c-3]));
        chk("t3_last", 32'(out_last), 32'(c == 6));
      end
      if (c == 7) begin
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_vld_off", 32'(out_valid), 32'd0);
      end
    end

    // Zero-length command
    launch(10'd5, 11'd0);
    chk("t4_len0_done", 32'(done), 32'd1);
    chk("t4_len0_busy", 32'(busy), 32'd0);
    chk("t4_len0_vld", 32'(out_valid), 32'd0);
    step();
    chk("t4_len0_pulse", 32'(done), 32'd0);
    chk("t4_len0_vld2", 32'(out_valid), 32'd0);

    // start while busy is ignored
    launch(10'd0, 11'd8);
    step();
    start = 1'b1; base = 10'd5; len = 11'd8;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) start = 1'b0;
      chk("t4_busy_dat", 32'(out_data), 32'(exp8[i]));
      chk("t4_busy_last", 32'(out_last), 32'(i == 7));
    end
    step();
    chk("t4_busy_done", 32'(done), 32'd1);
    step();
    chk("t4_no_second_cmd", 32'(busy), 32'd0);
    chk("t4_done_once", 32'(done), 32'd0);

    // Reset on the 5th output cycle of a len=8 burst
    launch(10'd0, 11'd8);
    repeat (6) step();
    chk("t5_pre_reset_dat", 32'(out_data), 32'h12E5);
    reset     = 1'b0;
    start     = 1'($urandom);
    base      = 10'($urandom);
    len       = 11'($urandom);
    out_ready = 1'($urandom);
    #1;
    check_reset_outputs("t5_rst");
    step();
    check_reset_outputs("t5_rst_hold");
    start     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_done", 32'(done), 32'd0);
      chk("t5_idle", 32'(busy), 32'd0);
    end
    launch(10'd2, 11'd2);
    step();
    step();
    chk("t5_w0_dat", 32'(out_data), 32'hDAC3);
    chk("t5_w0_last", 32'(out_last), 32'd0);
    step();
    chk("t5_w1_dat", 32'(out_data), 32'hFCD4);
    chk("t5_w1_last", 32'(out_last), 32'd1);
    step();
    chk("t5_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
